// File: rtl/rv_dbg_if.sv
// Test-access bus for rv_multicycle_top: backdoor preload/readback of memory and
// register file, plus observation of FSM state, PC and ALU output.
interface rv_dbg_if #(
  parameter int AW = 8
);
  logic          we;       // write wdata into the selected storage this cycle
  logic          sel_reg;  // 1: register file (addr[4:0]), 0: memory word addr
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;    // combinational readback of the selected location
  // state encoding: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMREAD, 4 MEMWB,
  //                 5 EXECUTEI, 6 ALUWB, 7 MEMWRITE
  logic [3:0]    state;
  logic [31:0]   pc;
  logic [31:0]   alu_out;

  modport master (output we, sel_reg, addr, wdata,
                  input  rdata, state, pc, alu_out);
  modport slave  (input  we, sel_reg, addr, wdata,
                  output rdata, state, pc, alu_out);
endinterface

// File: rtl/rv_multicycle_top.sv
// Multi-cycle RV32I subset core (loads, ADDI) with register file and unified memory.
// Optional stores (SB/SH/SW) are enabled by defining RV_STORE_EN.
module rv_multicycle_top #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic    clk,
  input  logic    reset,
  rv_dbg_if.slave dbg
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
`ifdef RV_STORE_EN
  localparam logic [6:0] OP_STORE = 7'b0100011;
`endif

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_EXECUTEI = 4'd5,
    S_ALUWB    = 4'd6,
    S_MEMWRITE = 4'd7
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, instr, data_q, result_q;
  logic [31:0]   mem  [MEM_WORDS];
  logic [31:0]   regs [32];

  logic [6:0]    opcode;
  logic [4:0]    rd, rs1;
  logic [2:0]    funct3;
  logic [31:0]   imm_i, rs1_val, alu_b, alu_out;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_rdata, load_val;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic          rf_we;
  logic [31:0]   rf_wdata;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];

`ifdef RV_STORE_EN
  logic [4:0]  rs2;
  logic [31:0] imm_s, rs2_val, st_data;
  logic [3:0]  st_be;

  assign rs2     = instr[24:20];
  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
  assign alu_b   = (opcode == OP_STORE) ? imm_s : imm_i;

  // Replicate the source so every enabled lane already holds the right bytes.
  always_comb begin
    st_data = rs2_val;
    st_be   = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_data = {4{rs2_val[7:0]}};
        st_be   = 4'b0001 << result_q[1:0];
      end
      2'b01: begin
        st_data = {2{rs2_val[15:0]}};
        st_be   = result_q[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end
`else
  assign alu_b = imm_i;
`endif

  assign alu_out = rs1_val + alu_b;

  // The address mux wraps modulo the memory depth by dropping upper bits.
  assign mem_idx   = (state == S_FETCH) ? pc[AW+1:2] : result_q[AW+1:2];
  assign mem_rdata = mem[mem_idx];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can infer a latch.
  always_comb begin
    ld_byte  = mem_rdata[7:0];
    load_val = mem_rdata;
    case (result_q[1:0])
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ;
    endcase
    ld_half = result_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_val = {24'h0, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_val = {16'h0, ld_half};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD:  state_nxt = S_MEMADR;
          OP_IMM:   state_nxt = (funct3 == 3'b000) ? S_EXECUTEI : S_FETCH;
`ifdef RV_STORE_EN
          OP_STORE: state_nxt = S_MEMADR;
`endif
          default:  state_nxt = S_FETCH;
        endcase
      end
`ifdef RV_STORE_EN
      S_MEMADR:   state_nxt = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
`else
      S_MEMADR:   state_nxt = S_MEMREAD;
`endif
      S_MEMREAD:  state_nxt = S_MEMWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      instr    <= 32'h0;
      data_q   <= 32'h0;
      result_q <= 32'h0;
    end else begin
      case (state)
        S_FETCH: begin
          instr <= mem_rdata;
          pc    <= pc + 32'd4;
        end
        S_MEMADR, S_EXECUTEI: result_q <= alu_out;
        S_MEMREAD:            data_q   <= load_val;
        default: ;
      endcase
    end
  end

  assign rf_we    = ((state == S_MEMWB) || (state == S_ALUWB)) && (rd != 5'd0);
  assign rf_wdata = (state == S_MEMWB) ? data_q : result_q;

  // NOTE: register file and memory have no reset so preloaded contents survive
  // reset; the async reset already keeps the FSM from writing while asserted.
  always_ff @(posedge clk) begin
    if (dbg.we && dbg.sel_reg) begin
      if (dbg.addr[4:0] != 5'd0) regs[dbg.addr[4:0]] <= dbg.wdata;
    end else if (rf_we) begin
      regs[rd] <= rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (dbg.we && !dbg.sel_reg) begin
      mem[dbg.addr] <= dbg.wdata;
`ifdef RV_STORE_EN
    end else if (state == S_MEMWRITE) begin
      if (st_be[0]) mem[mem_idx][7:0]   <= st_data[7:0];
      if (st_be[1]) mem[mem_idx][15:8]  <= st_data[15:8];
      if (st_be[2]) mem[mem_idx][23:16] <= st_data[23:16];
      if (st_be[3]) mem[mem_idx][31:24] <= st_data[31:24];
`endif
    end
  end

  assign dbg.rdata   = !dbg.sel_reg            ? mem[dbg.addr] :
                       (dbg.addr[4:0] == 5'd0) ? 32'h0 : regs[dbg.addr[4:0]];
  assign dbg.state   = state;
  assign dbg.pc      = pc;
  assign dbg.alu_out = alu_out;
endmodule

// File: tb/tb_rv_multicycle_top.sv
// Directed bench for rv_multicycle_top: an instruction-level model predicts the
// per-cycle state/PC/ALU trace and architectural results, checked every cycle.
module tb_rv_multicycle_top;
  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                         ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4, ST_EXECUTEI = 4'd5,
                         ST_ALUWB = 4'd6, ST_MEMWRITE = 4'd7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv_dbg_if #(.AW(8)) dbg ();

  rv_multicycle_top #(.MEM_WORDS(256), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .dbg   (dbg)
  );

  typedef struct {
    logic [3:0]  st;
    bit          chk_pc;
    logic [31:0] pc;
    bit          chk_alu;
    logic [31:0] alu;
    bit          chk_rb;
    bit          rb_reg;
    logic [7:0]  rb_addr;
    logic [31:0] rb_val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] prog_q[$];
  bit          hl_q[$];
  logic [31:0] lit_q[$];
  logic [31:0] mem_m [256];
  logic [31:0] reg_m [32];
  int          total = 0;
  int          bad = 0;
  bit          running = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  // Load value from a memory word by the ISA's width/sign rules.
  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w >> (8 * off)) & 32'hff);
    h = 16'((w >> (16 * off[1])) & 32'hffff);
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b100:  return 32'(b);
      3'b001:  return 32'($signed(h));
      3'b101:  return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic add(input logic [31:0] w, input bit hl, input logic [31:0] lit);
    prog_q.push_back(w);
    hl_q.push_back(hl);
    lit_q.push_back(lit);
  endtask

  task automatic push(input logic [3:0] st, input bit ca, input logic [31:0] al);
    exp_t e;
    e = '{st: st, chk_pc: 0, pc: 0, chk_alu: ca, alu: al,
          chk_rb: 0, rb_reg: 0, rb_addr: 0, rb_val: 0};
    exp_q.push_back(e);
  endtask

  task automatic wr(input bit sel, input logic [7:0] a, input logic [31:0] d);
    dbg.sel_reg = sel;
    dbg.addr    = a;
    dbg.wdata   = d;
    dbg.we      = 1'b1;
    @(posedge clk);
    #1 dbg.we   = 1'b0;
  endtask

  task automatic rd_check(input string name, input bit sel, input logic [7:0] a,
                          input logic [31:0] req);
    dbg.sel_reg = sel;
    dbg.addr    = a;
    #1 check(name, dbg.rdata, req);
  endtask

  // Per-cycle compare against the model's expected trace.
  always @(negedge clk) begin
    if (running && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("state", 32'(dbg.state), 32'(e.st));
      if (e.chk_pc)  check("pc", dbg.pc, e.pc);
      if (e.chk_alu) check("alu_out", dbg.alu_out, e.alu);
      if (e.chk_rb) begin
        dbg.sel_reg = e.rb_reg;
        dbg.addr    = e.rb_addr;
        #1 check(e.rb_reg ? "reg_result" : "mem_result", dbg.rdata, e.rb_val);
      end
    end
  end

  initial begin
    logic [31:0] pc_m, w, a, ea, v, imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    bit          pend, pend_reg, last, has_v;
    logic [7:0]  pend_addr;
    logic [31:0] pend_val;
    int          n, cyc;

    reset = 1'b1;
    dbg.we = 1'b0; dbg.sel_reg = 1'b0; dbg.addr = '0; dbg.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(dbg.state), 32'(ST_FETCH));
    check("reset_pc", dbg.pc, 32'h0);

    // Program: x2 = 0x10 so imm 0x90 reaches byte address 0xa0 (M[40]).
    for (int k = 0; k < 4; k++) begin : g_lb
      logic [31:0] l [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      add(enc_i(12'h090 + 12'(k), 5'd2, 3'b000, 5'd1, 7'h03), 1, l[k]);
    end
    for (int k = 0; k < 4; k++) begin : g_lbs
      logic [31:0] l [4] = '{32'hfffffff4, 32'hffffffe5, 32'hffffffd6, 32'hffffffc7};
      add(enc_i(12'h098 + 12'(k), 5'd2, 3'b000, 5'd1, 7'h03), 1, l[k]);
    end
    for (int k = 0; k < 4; k++) begin : g_lbu
      logic [31:0] l [4] = '{32'hf4, 32'he5, 32'hd6, 32'hc7};
      add(enc_i(12'h098 + 12'(k), 5'd2, 3'b100, 5'd1, 7'h03), 1, l[k]);
    end
    for (int k = 0; k < 4; k++) begin : g_lh
      logic [11:0] o [4] = '{12'h090, 12'h092, 12'h098, 12'h09a};
      logic [31:0] l [4] = '{32'h2211, 32'h4433, 32'hffffe5f4, 32'hffffc7d6};
      logic [31:0] u [4] = '{32'h2211, 32'h4433, 32'he5f4, 32'hc7d6};
      add(enc_i(o[k], 5'd2, 3'b001, 5'd1, 7'h03), 1, l[k]);
      add(enc_i(o[k], 5'd2, 3'b101, 5'd1, 7'h03), 1, u[k]);
    end
    for (int k = 0; k < 4; k++) begin : g_lb80
      logic [11:0] o [4] = '{12'h0a0, 12'h0a5, 12'h0aa, 12'h0af};
      add(enc_i(o[k], 5'd2, 3'b000, 5'd1, 7'h03), 1, 32'hffffff80);
    end
    for (int k = 0; k < 4; k++) begin : g_lh80
      logic [11:0] o [4] = '{12'h0a4, 12'h0a6, 12'h0a8, 12'h0aa};
      logic [31:0] l [4] = '{32'hffff8000, 32'h0, 32'h0, 32'h80};
      add(enc_i(o[k], 5'd2, 3'b001, 5'd1, 7'h03), 1, l[k]);
    end
    add(enc_i(12'hfff, 5'd0, 3'b000, 5'd3, 7'h13), 1, 32'hffffffff);  // addi x3,x0,-1
    add(enc_i(12'h000, 5'd0, 3'b010, 5'd4, 7'h03), 1, prog_q[0]);     // lw x4,0(x0)
    add(enc_i(12'h005, 5'd0, 3'b000, 5'd0, 7'h13), 1, 32'h0);         // addi x0,x0,5
    add(enc_s(12'h0b1, 5'd3, 5'd0, 3'b000), 0, 32'h0);                // sb x3,0xb1(x0)
    add(enc_i(12'h090, 5'd2, 3'b000, 5'd5, 7'h03), 0, 32'h0);         // aborted by reset

    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    for (int i = 0; i < prog_q.size(); i++) mem_m[i] = prog_q[i];
    mem_m[40] = 32'h44332211;
    mem_m[42] = 32'hc7d6e5f4;
    for (int i = 0; i < 4; i++) mem_m[44 + i] = 32'h80 << (8 * i);
    for (int i = 0; i < 32; i++) reg_m[i] = 32'h0;
    reg_m[2] = 32'h10;
    reg_m[4] = 32'hdeadbeef;
    reg_m[5] = 32'h5a5a5a5a;
    for (int i = 0; i < 256; i++) wr(1'b0, 8'(i), mem_m[i]);
    for (int i = 1; i < 32; i++) wr(1'b1, 8'(i), reg_m[i]);

    // Instruction-level model run producing the expected per-cycle trace.
    pc_m = 32'h0; pend = 0; pend_reg = 0; pend_addr = 0; pend_val = 0;
    n = prog_q.size();
    for (int i = 0; i < n; i++) begin
      exp_t e;
      last = (i == n - 1);
      w   = mem_m[(pc_m >> 2) % 256];
      op  = w[6:0]; f3 = w[14:12]; rd = w[11:7]; rs1 = w[19:15]; rs2 = w[24:20];
      a   = reg_m[rs1];
      e = '{st: ST_FETCH, chk_pc: 1, pc: pc_m, chk_alu: 0, alu: 0, chk_rb: pend,
            rb_reg: pend_reg, rb_addr: pend_addr, rb_val: pend_val};
      exp_q.push_back(e);
      pend = 0; has_v = 0; v = 0;
      push(ST_DECODE, 0, 0);
      if (op == 7'b0000011) begin
        imm = 32'($signed(w[31:20]));
        ea  = a + imm;
        push(ST_MEMADR, 1, ea);
        push(ST_MEMREAD, 0, 0);
        if (!last) begin
          push(ST_MEMWB, 0, 0);
          v = m_load(mem_m[(ea >> 2) % 256], ea[1:0], f3);
          if (rd != 0) reg_m[rd] = v;
          pend = 1; pend_reg = 1; pend_addr = 8'(rd); pend_val = reg_m[rd];
          has_v = 1;
        end
      end else if (op == 7'b0010011 && f3 == 3'b000) begin
        imm = 32'($signed(w[31:20]));
        v   = a + imm;
        push(ST_EXECUTEI, 1, v);
        push(ST_ALUWB, 0, 0);
        if (rd != 0) reg_m[rd] = v;
        v = reg_m[rd];
        pend = 1; pend_reg = 1; pend_addr = 8'(rd); pend_val = v;
        has_v = 1;
`ifdef RV_STORE_EN
      end else if (op == 7'b0100011) begin
        logic [31:0] mask, sv;
        imm = 32'($signed({w[31:25], w[11:7]}));
        ea  = a + imm;
        push(ST_MEMADR, 1, ea);
        push(ST_MEMWRITE, 0, 0);
        case (f3[1:0])
          2'b00:   begin mask = 32'hff << (8 * ea[1:0]);    sv = reg_m[rs2] << (8 * ea[1:0]); end
          2'b01:   begin mask = 32'hffff << (16 * ea[1]);   sv = reg_m[rs2] << (16 * ea[1]); end
          default: begin mask = 32'hffffffff;               sv = reg_m[rs2]; end
        endcase
        mem_m[(ea >> 2) % 256] = (mem_m[(ea >> 2) % 256] & ~mask) | (sv & mask);
        pend = 1; pend_reg = 0; pend_addr = 8'((ea >> 2) % 256);
        pend_val = mem_m[(ea >> 2) % 256];
`endif
      end
      if (hl_q[i]) check("model_vs_literal", has_v ? v : 32'hxxxxxxxx, lit_q[i]);
      pc_m = pc_m + 4;
    end

    @(posedge clk);
    #1 reset = 1'b0;
    running = 1'b1;

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 2000) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    if (exp_q.size() != 0) check("trace_timeout", 32'(exp_q.size()), 32'h0);

    // The final lb x5 is now in MEMREAD; reset must abort it immediately.
    running = 1'b0;
    check("pre_abort_state", 32'(dbg.state), 32'(ST_MEMREAD));
    reset = 1'b1;
    #1;
    check("abort_state", 32'(dbg.state), 32'(ST_FETCH));
    check("abort_pc", dbg.pc, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rd_check("abort_rd_unchanged", 1'b1, 8'd5, 32'h5a5a5a5a);
    rd_check("final_x1", 1'b1, 8'd1, 32'h80);
    rd_check("final_x3", 1'b1, 8'd3, 32'hffffffff);
    rd_check("final_x4", 1'b1, 8'd4, prog_q[0]);
    rd_check("final_x0", 1'b1, 8'd0, 32'h0);
`ifdef RV_STORE_EN
    rd_check("final_m44", 1'b0, 8'd44, 32'h0000ff80);
`else
    rd_check("final_m44", 1'b0, 8'd44, 32'h00000080);
`endif
    check("held_state", 32'(dbg.state), 32'(ST_FETCH));
    check("held_pc", dbg.pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv_multicycle_top.md
Name: rv_multicycle_top

Overview:
- Self-contained multi-cycle RV32I subset processor: core, 32x32 register file, control FSM and unified word-addressed instruction/data memory.
- Covers loads (LB/LH/LW/LBU/LHU) and ADDI; stores are optional.
- Top-level integration block for directed memory-access benches; only clock and reset are external.

Parameters:
- MEM_WORDS, 256, depth of unified memory in 32-bit words; memory index = byte address[log2(MEM_WORDS)+1:2].
- RESET_PC, 32'h0, PC value on reset.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears PC and FSM.

Behaviour:
- Reset: async active-high. While asserted: FSM = FETCH, PC = RESET_PC, instruction/data/ALU-result registers = 0.
- Register file and memory are not reset; contents preloaded before/while reset is held survive.
- x0 reads 0 and ignores writes.
- Memory: array M of 32-bit words, little-endian (byte address 4k+0 = M[k][7:0]).
  - Combinational read of M[addr>>2].
  - Address mux: PC in FETCH, registered ALU result otherwise.
- FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, EXECUTEI, ALUWB (plus MEMWRITE with option).
- FETCH: latch instr = M[PC>>2]; PC <= PC+4; next DECODE.
- DECODE: decode opcode, rs1, rd, funct3; imm_ext = sign-extended I-immediate (instr[31:20]); read rs1.
  - Next state by opcode: 0000011 -> MEMADR; 0010011 with funct3=000 -> EXECUTEI; else -> FETCH (NOP, PC already advanced).
- MEMADR: ALU a = rs1 value, b = imm_ext, out = a+b (32-bit wrap); out registered as result; next MEMREAD.
- MEMREAD: memory address = registered result; data register <= extracted load value; next MEMWB.
- MEMWB: result = data; rd written on the clock edge leaving MEMWB; next FETCH.
- EXECUTEI: ALU computes rs1+imm; next ALUWB.
- ALUWB: write ALU result to rd; next FETCH.
- Load latency: 5 cycles (FETCH..MEMWB); ADDI: 4 cycles.
- Load extraction, funct3 (b = addr[1:0]):
  - 000 LB: byte b, sign-extend bit 7.
  - 100 LBU: byte b, zero-extend.
  - 001 LH: halfword addr[1] (addr[0] ignored), sign-extend bit 15.
  - 101 LHU: same halfword, zero-extend.
  - 010 LW: whole word, addr[1:0] ignored.
  - Other funct3: treated as LW.
- Sign bit must come from the selected byte/half only, never from another lane.
- No misalignment traps. Addresses beyond MEM_WORDS wrap modulo depth.
- Reset asserted mid-instruction: abort immediately, no register write, restart at FETCH/RESET_PC.

Optional Feature:
- Macro RV_STORE_EN.
- Defined: opcode 0100011 supported. DECODE -> MEMADR using S-immediate {instr[31:25], instr[11:7]} -> MEMWRITE -> FETCH.
  - MEMWRITE writes rs2 with byte enables: SB = byte lane addr[1:0] (rs2[7:0]); SH = half addr[1] (rs2[15:0]); SW = full word.
  - Store latency 4 cycles.
- Undefined: store opcode treated as NOP (DECODE -> FETCH); memory never written by the core.

Test Plan:
- Preload M[40]=32'h44332211, x2=0x10. Run lb x1,0x90(x2) through lb x1,0x93(x2) -> x1 = 0x11, 0x22, 0x33, 0x44.
  - Each load: state sequence DECODE, MEMADR (alu out 0xa0..0xa3), MEMREAD, MEMWB, FETCH.
  - PC advances by 4 per instruction.
- M[42]=32'hc7d6e5f4; lb at 0xa8..0xab -> 0xfffffff4, 0xffffffe5, 0xffffffd6, 0xffffffc7.
  - lbu at the same addresses -> 0xf4, 0xe5, 0xd6, 0xc7.
- lh/lhu at 0xa0, 0xa2, 0xa8, 0xaa:
  - lh -> 0x2211, 0x4433, 0xffffe5f4, 0xffffc7d6.
  - lhu -> 0x2211, 0x4433, 0xe5f4, 0xc7d6.
- M[44..47] = 0x80 << (8*i):
  - lb at 0xb0, 0xb5, 0xba, 0xbf -> 0xffffff80 each.
  - lh at 0xb4 -> 0xffff8000; at 0xb6 -> 0; at 0xb8 -> 0; at 0xba -> 0x80.
- addi x3,x0,-1 then lw x4,0(x0) -> x3 = 0xffffffff; x4 = M[0]. Write to x0 ignored: x0 reads 0.
- Assert reset during MEMREAD -> state FETCH and PC=0 before the next edge; rd unchanged.
  - With RV_STORE_EN: sb x3,0xb1(x0) -> M[44] = 0x0000ff80.
